// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch unit with redirect and misalignment fault
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        pend_valid;   // aligned redirect seen while a request is outstanding
  logic [31:0] pend_pc;
  logic        pend_fault;   // misaligned redirect seen while a request is outstanding

  logic redirect_bad;
  assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);

  // Fetch FSM; every output is a register. Entering FETCH leaves mem_req low for
  // one cycle, which gives the per-instruction bubble and the post-discard gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_pc     <= 32'h0;
      pend_fault  <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
      pc          <= 32'h0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_bad) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            if (redirect) fetch_pc <= redirect_pc;
            state <= FETCH;
          end
        end

        FETCH: begin
          if (!mem_req) begin
            // No request outstanding: a redirect here simply replaces the address.
            if (redirect_bad) begin
              fault <= 1'b1;
              state <= FAULT;
            end else if (redirect) begin
              fetch_pc <= redirect_pc;
              mem_req  <= 1'b1;
              mem_addr <= redirect_pc;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= fetch_pc;
            end
          end else begin
            // Request outstanding: it is never withdrawn, redirects are remembered.
            if (redirect_bad) begin
              fault      <= 1'b1;
              pend_fault <= 1'b1;
            end else if (redirect && !pend_fault) begin
              pend_valid <= 1'b1;
              pend_pc    <= redirect_pc;
            end
            if (mem_ack) begin
              mem_req    <= 1'b0;
              mem_addr   <= 32'h0;
              pend_valid <= 1'b0;
              pend_fault <= 1'b0;
              if (pend_fault || redirect_bad) begin
                state <= FAULT;
              end else if (redirect) begin
                fetch_pc <= redirect_pc;
              end else if (pend_valid) begin
                fetch_pc <= pend_pc;
              end else begin
                instruction <= mem_rdata;
                pc          <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
                instr_valid <= 1'b1;
                state       <= HOLD;
              end
            end
          end
        end

        HOLD: begin
          if (redirect_bad) begin
            instr_valid <= 1'b0;
            fault       <= 1'b1;
            state       <= FAULT;
          end else if (redirect) begin
            instr_valid <= 1'b0;
            fetch_pc    <= redirect_pc;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end

        FAULT: begin
          mem_req     <= 1'b0;
          mem_addr    <= 32'h0;
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset (word-aligned).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset SHALL be asynchronous and active-low.
REQ-004 mem_req  output  1  read request to instruction memory.
REQ-005 mem_addr  output  32  byte address of the read; valid while mem_req=1.
REQ-006 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-007 mem_rdata  input  32  instruction word returned by memory.
REQ-008 instruction  output  32  instruction word presented to the CPU.
REQ-009 instr_valid  output  1  instruction and pc hold a valid, unconsumed fetch.
REQ-010 instr_ready  input  1  CPU consumes the presented instruction.
REQ-011 pc  output  32  address of the presented instruction.
REQ-012 redirect  input  1  branch/jump taken; fetch SHALL restart at redirect_pc.
REQ-013 redirect_pc  input  32  redirect target address.
REQ-014 fault  output  1  sticky misaligned-target flag.

Function
REQ-015 FSM SHALL have exactly four states: IDLE, FETCH, HOLD, FAULT; internal register fetch_pc SHALL hold the next address to fetch.
REQ-016 IDLE: all outputs 0; SHALL go to FETCH on the next edge unconditionally.
REQ-017 FETCH: mem_req=1, mem_addr=fetch_pc, both held stable until mem_ack=1; memory may take any number of cycles.
REQ-018 FETCH with mem_ack=1 and no redirect pending: instruction<=mem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, state->HOLD; latency from request to instr_valid SHALL be 1 cycle after the ack cycle.
REQ-019 HOLD: mem_req=0, instr_valid=1, instruction/pc stable; on instr_ready=1 SHALL go to FETCH next cycle (one bubble per instruction).
REQ-020 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), no fault.
REQ-021 Redirect in IDLE or HOLD with redirect_pc[1:0]=0: fetch_pc<=redirect_pc, instr_valid<=0, state->FETCH; applies even if instr_ready=1 the same cycle (instruction counted as consumed).
REQ-022 Redirect in FETCH with aligned target: request SHALL NOT be withdrawn; target stored as pending; at mem_ack data SHALL be discarded (instr_valid stays 0), fetch_pc<=pending target, state remains FETCH with mem_req dropping for exactly one cycle.
REQ-023 Redirect in FETCH coincident with mem_ack: the returned data SHALL be discarded and redirect_pc used directly.
REQ-024 Multiple redirects before ack: latest target SHALL win.
REQ-025 Redirect with redirect_pc[1:0]!=0 in any non-FAULT state: fault<=1, instr_valid<=0, state->FAULT; if in FETCH, mem_req held until mem_ack, then FAULT.
REQ-026 FAULT: mem_req=0, instr_valid=0, fault=1; SHALL remain until reset; redirect ignored.
REQ-027 mem_ack received outside FETCH SHALL be ignored.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, pending redirect cleared, and mem_req, mem_addr, instruction, instr_valid, pc, fault all 0.
REQ-029 Reset asserted mid-fetch SHALL abandon the request; first request after release SHALL be to RESET_PC.

Verification
REQ-030 Reset release, memory acks after 3 cycles with 32'h2002_0010, instr_ready=1 -> mem_addr=0 first, instr_valid=1 with instruction=32'h2002_0010, pc=0; next mem_addr=4.
REQ-031 instr_ready=0 for 5 cycles in HOLD -> instruction/pc unchanged, mem_req=0 throughout; no new fetch until ready.
REQ-032 Redirect to 32'h0000_0040 while FETCH waits on ack for addr 8 -> mem_addr stays 8 until ack, data discarded, one idle cycle, then mem_addr=32'h40, pc=32'h40 on next valid.
REQ-033 RESET_PC=32'hFFFF_FFFC, two fetches -> pc=32'hFFFF_FFFC then pc=0, fault=0.
REQ-034 Redirect to 32'h0000_0042 in HOLD -> fault=1, instr_valid=0, mem_req=0 until reset_n pulsed low; after release fetch resumes at RESET_PC.
REQ-035 reset_n pulsed low mid-FETCH (async, between edges) -> outputs 0 immediately; late mem_ack ignored; first post-reset mem_addr=RESET_PC.
